// File: rtl/program_sequencer.sv
// Loader/run sequencer in front of the instruction store: burst-loads words, then steps PC through the program.
// Store writes are registered one cycle after accept; in_ready is a pure state decode and never depends on in_valid.
module program_sequencer #(
  parameter int          ADDR_W      = 5,
  parameter int          DATA_W      = 16,
  parameter logic [3:0]  HALT_OPCODE = 4'b1111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_is_instruction,
  output logic              in_ready,
  input  logic              run_start,
  input  logic              halt_req,
  input  logic              exec_busy,
  input  logic [DATA_W-1:0] instruction,
  output logic              load,
  output logic              is_instruction,
  output logic [ADDR_W-1:0] load_address,
  output logic [DATA_W-1:0] cpu_input,
  output logic [ADDR_W-1:0] program_counter,
  output logic              exec_valid,
  output logic              halted,
  output logic              loading
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HALT} state_t;

  localparam logic [ADDR_W:0]   MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PC_LAST   = {ADDR_W{1'b1}};

  state_t            state;
  logic [ADDR_W:0]   words_left;
  logic [ADDR_W-1:0] instr_addr;
  logic [ADDR_W-1:0] data_addr;
  logic [ADDR_W:0]   burst_len;
  logic              stop_req;
  logic              accept;

  assign stop_req   = (instruction[DATA_W-1 -: 4] == HALT_OPCODE) || halt_req;
  assign in_ready   = (state == S_LOAD);
  assign loading    = (state == S_LOAD);
  assign halted     = (state == S_HALT);
  assign exec_valid = (state == S_RUN) && !stop_req;
  assign accept     = in_valid && in_ready;
  assign burst_len  = (load_count > MAX_COUNT) ? MAX_COUNT : load_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      words_left      <= '0;
      instr_addr      <= '0;
      data_addr       <= '0;
      load            <= 1'b0;
      is_instruction  <= 1'b0;
      load_address    <= '0;
      cpu_input       <= '0;
      program_counter <= '0;
    end else begin
      load <= 1'b0;
      unique case (state)
        S_IDLE, S_HALT: begin
          // A load request takes priority over run, even an empty one.
          if (load_start) begin
            if (load_count != '0) begin
              state      <= S_LOAD;
              words_left <= burst_len;
              instr_addr <= '0;
              data_addr  <= '0;
            end
          end else if (run_start) begin
            state           <= S_RUN;
            program_counter <= '0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            load           <= 1'b1;
            is_instruction <= in_is_instruction;
            cpu_input      <= in_data;
            if (in_is_instruction) begin
              load_address <= instr_addr;
              instr_addr   <= instr_addr + ADDR_ONE;
            end else begin
              load_address <= data_addr;
              data_addr    <= data_addr + ADDR_ONE;
            end
            words_left <= words_left - CNT_ONE;
            if (words_left == CNT_ONE) state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (stop_req) begin
            state <= S_HALT;
          end else if (!exec_busy) begin
            // The last address halts instead of wrapping back to 0.
            if (program_counter == PC_LAST) state <= S_HALT;
            else program_counter <= program_counter + ADDR_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
